usb_status_transmitter: RTL and testbench

Transmit-direction counterpart of `usb_controller`: sends fixed-format status frames to the host through the FT245-style USB FIFO write port (`txe_n`/`wr_n`). It shares the 8-bit data bus with the receive path and requests ownership before driving it. Each frame carries a sync byte, the 16 panel-switch bits, a rolling sequence number and an optional checksum. Frames are triggered by a one-cycle request from the cube control logic.

---
 rtl/usb_pkg.sv | 44 ++++
 rtl/sync_2ff.sv | 23 ++
 rtl/usb_status_transmitter.sv | 149 ++++++++++++++
 tb/tb_usb_status_transmitter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared definitions for the USB status transmit path: FSM encodings, sync byte, frame length.
// Build option: USB_TX_CHECKSUM_EN appends an XOR checksum byte to every frame.
package usb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_REQ_BUS  = 3'd1,
      ST_WAIT_TXE = 3'd2,
      ST_SETUP    = 3'd3,
      ST_STROBE   = 3'd4,
      ST_HOLD     = 3'd5,
      ST_RECOVER  = 3'd6,
      ST_DONE     = 3'd7
   } tx_state_t;

   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
   localparam int         BYTE_IDX_W        = 3;

`ifdef USB_TX_CHECKSUM_EN
   localparam int FRAME_BYTES = 5;
`else
   localparam int FRAME_BYTES = 4;
`endif

   // Byte idx of a frame: sync, switches high, switches low, seq, optional checksum.
   function automatic logic [7:0] frame_byte(input logic [BYTE_IDX_W-1:0] idx,
                                             input logic [7:0]            sync,
                                             input logic [15:0]           sw,
                                             input logic [7:0]            seq);
      logic [7:0] b;
      case (idx)
         3'd0:    b = sync;
         3'd1:    b = sw[15:8];
         3'd2:    b = sw[7:0];
         3'd3:    b = seq;
`ifdef USB_TX_CHECKSUM_EN
         3'd4:    b = sync ^ sw[15:8] ^ sw[7:0] ^ seq;
`endif
         default: b = 8'h00;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; both flops reset to RESET_VAL.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/usb_status_transmitter.sv
// Sends sync/switch/sequence(/checksum) status frames through the FT245 write port.
// Build option: USB_TX_CHECKSUM_EN (see usb_pkg) selects the 5-byte checksummed frame.
module usb_status_transmitter
   import usb_pkg::*;
#(
   parameter int         WR_LOW_CYCLES  = 3,
   parameter int         SETUP_CYCLES   = 1,
   parameter int         HOLD_CYCLES    = 1,
   parameter int         RECOVER_CYCLES = 4,
   parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        send_req,
   input  logic [15:0] panel_switches,
   input  logic        txe_n_raw,
   input  logic        bus_grant,
   output logic        bus_req,
   output logic [7:0]  data_bus_out,
   output logic        data_out_enable,
   output logic        wr_n,
   output logic        busy,
   output logic        frame_done,
   output logic [2:0]  state_out
);

   localparam int CNT_W = 8;
   // Below 3 recover cycles the synchronizer could still present a stale low txe_n.
   localparam int RECOVER_EFF = (RECOVER_CYCLES < 3) ? 3 : RECOVER_CYCLES;

   localparam logic [CNT_W-1:0]      SETUP_LAST   = CNT_W'(SETUP_CYCLES - 1);
   localparam logic [CNT_W-1:0]      STROBE_LAST  = CNT_W'(WR_LOW_CYCLES - 1);
   localparam logic [CNT_W-1:0]      HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0]      RECOVER_LAST = CNT_W'(RECOVER_EFF - 1);
   localparam logic [BYTE_IDX_W-1:0] LAST_BYTE    = BYTE_IDX_W'(FRAME_BYTES - 1);

   tx_state_t             state;
   logic [CNT_W-1:0]      cnt;
   logic [BYTE_IDX_W-1:0] byte_idx;
   logic [15:0]           sw_q;
   logic [7:0]            seq_q;
   logic [7:0]            seq;
   logic                  txe_n;
   logic [7:0]            cur_byte;

   sync_2ff #(.RESET_VAL(1'b1)) u_txe_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (txe_n_raw),
      .q       (txe_n)
   );

   assign cur_byte  = frame_byte(byte_idx, SYNC_BYTE, sw_q, seq_q);
   assign state_out = state;

   // Handshake: bus_req rises in REQ_BUS and stays up through RECOVER of the last
   // byte; the bus is driven only after bus_grant is seen, and a byte in flight
   // (SETUP..HOLD) finishes regardless of bus_grant or txe_n.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state           <= ST_IDLE;
         cnt             <= '0;
         byte_idx        <= '0;
         sw_q            <= '0;
         seq_q           <= '0;
         seq             <= '0;
         bus_req         <= 1'b0;
         data_bus_out    <= '0;
         data_out_enable <= 1'b0;
         wr_n            <= 1'b1;
         busy            <= 1'b0;
         frame_done      <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (send_req) begin
                  sw_q     <= panel_switches;
                  seq_q    <= seq;
                  byte_idx <= '0;
                  busy     <= 1'b1;
                  bus_req  <= 1'b1;
                  state    <= ST_REQ_BUS;
               end
            end
            ST_REQ_BUS: begin
               if (bus_grant) state <= ST_WAIT_TXE;
            end
            ST_WAIT_TXE: begin
               if (!txe_n) begin
                  cnt             <= '0;
                  data_out_enable <= 1'b1;
                  data_bus_out    <= cur_byte;
                  state           <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (cnt == SETUP_LAST) begin
                  cnt   <= '0;
                  wr_n  <= 1'b0;
                  state <= ST_STROBE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_STROBE: begin
               if (cnt == STROBE_LAST) begin
                  cnt   <= '0;
                  wr_n  <= 1'b1;
                  state <= ST_HOLD;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_HOLD: begin
               if (cnt == HOLD_LAST) begin
                  cnt             <= '0;
                  data_out_enable <= 1'b0;
                  state           <= ST_RECOVER;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_RECOVER: begin
               if (cnt == RECOVER_LAST) begin
                  cnt <= '0;
                  if (byte_idx == LAST_BYTE) begin
                     frame_done <= 1'b1;
                     bus_req    <= 1'b0;
                     state      <= ST_DONE;
                  end else begin
                     byte_idx <= byte_idx + BYTE_IDX_W'(1);
                     state    <= ST_WAIT_TXE;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_DONE: begin
               seq   <= seq + 8'd1;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_usb_status_transmitter.sv
// Directed bench for usb_status_transmitter: frame bytes, timing, back-pressure, arbitration, reset, seq wrap.
module tb_usb_status_transmitter;

`ifdef USB_TX_CHECKSUM_EN
   localparam int NB = 5;
`else
   localparam int NB = 4;
`endif
   localparam int FRAME_CYC = 2 + NB * 10;
   localparam int LAT_MAX   = 400;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        send_req = 1'b0;
   logic [15:0] panel_switches = 16'h0000;
   logic        txe_n_raw = 1'b1;
   logic        bus_grant = 1'b0;
   logic        bus_req;
   logic [7:0]  data_bus_out;
   logic        data_out_enable;
   logic        wr_n;
   logic        busy;
   logic        frame_done;
   logic [2:0]  state_out;

   int          total = 0;
   int          bad = 0;
   logic [7:0]  exp_q[$];
   logic [7:0]  exp_seq = 8'h00;
   int          bytes_seen = 0;
   int          done_cnt = 0;
   logic        prev_wr_n = 1'b1;
   logic [7:0]  prev_data = 8'h00;

   usb_status_transmitter dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .send_req        (send_req),
      .panel_switches  (panel_switches),
      .txe_n_raw       (txe_n_raw),
      .bus_grant       (bus_grant),
      .bus_req         (bus_req),
      .data_bus_out    (data_bus_out),
      .data_out_enable (data_out_enable),
      .wr_n            (wr_n),
      .busy            (busy),
      .frame_done      (frame_done),
      .state_out       (state_out)
   );

   // clock / watchdog
   always #10 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // scoreboard: the FT245 latches data on the wr_n rising edge
   always @(negedge clk) begin
      if (reset_n) begin
         if (!prev_wr_n && wr_n) begin
            bytes_seen++;
            check("oe_at_wr", data_out_enable, 1);
            check("q_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("byte", data_bus_out, exp_q.pop_front());
         end
         if (!prev_wr_n && !wr_n) check("data_stable", data_bus_out, prev_data);
         if (frame_done) done_cnt++;
      end
      prev_wr_n = wr_n;
      prev_data = data_bus_out;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_frame(input logic [15:0] sw);
      logic [7:0] b0, b1, b2, b3;
      b0 = 8'hA5;
      b1 = sw[15:8];
      b2 = sw[7:0];
      b3 = exp_seq;
      exp_q.push_back(b0);
      exp_q.push_back(b1);
      exp_q.push_back(b2);
      exp_q.push_back(b3);
      if (NB == 5) exp_q.push_back(b0 ^ b1 ^ b2 ^ b3);
   endtask

   // Pulses send_req (sampled at the next edge) and waits for frame_done.
   task automatic run_frame(input string tag, input logic [15:0] sw, input int exp_lat);
      int lat;
      panel_switches = sw;
      push_frame(sw);
      send_req = 1'b1;
      tick();
      send_req = 1'b0;
      lat = 1;
      while (!frame_done && lat < LAT_MAX) begin
         tick();
         lat++;
      end
      if (exp_lat > 0) check({tag, "_lat"}, lat, exp_lat);
      else             check({tag, "_no_timeout"}, lat < LAT_MAX, 1);
      tick();
      check({tag, "_done_one_cycle"}, frame_done, 0);
      check({tag, "_idle_after"}, busy, 0);
      check({tag, "_all_bytes"}, exp_q.size(), 0);
      exp_q.delete();
      exp_seq = exp_seq + 8'd1;
   endtask

   initial begin
      int base;
      int k;

      // reset values
      reset_n = 1'b0;
      repeat (3) tick();
      check("rst_wr_n", wr_n, 1);
      check("rst_oe", data_out_enable, 0);
      check("rst_data", data_bus_out, 8'h00);
      check("rst_bus_req", bus_req, 0);
      check("rst_busy", busy, 0);
      check("rst_done", frame_done, 0);
      check("rst_state", state_out, 3'd0);
      reset_n   = 1'b1;
      bus_grant = 1'b1;
      txe_n_raw = 1'b0;
      repeat (3) tick();

      // single frame with request-to-output timing
      fork
         run_frame("single", 16'hFDEC, FRAME_CYC);
         begin
            tick();
            check("t1_busy", busy, 1);
            check("t1_bus_req", bus_req, 1);
            tick();
            check("t2_oe", data_out_enable, 0);
            tick();
            check("t3_oe", data_out_enable, 1);
         end
      join

      // back-pressure before byte 2
      base = bytes_seen;
      fork
         run_frame("bp", 16'hFDEC, 0);
         begin
            k = 0;
            while (bytes_seen < base + 2 && k < 200) begin
               @(negedge clk);
               #1;
               k++;
            end
            check("bp_reach_byte2", bytes_seen, base + 2);
            txe_n_raw = 1'b1;
            repeat (5) begin
               @(negedge clk);
               #1;
            end
            for (int i = 0; i < 10; i++) begin
               check("bp_state", state_out, 3'd2);
               check("bp_wr_n", wr_n, 1);
               @(negedge clk);
               #1;
            end
            check("bp_no_write", bytes_seen, base + 2);
            txe_n_raw = 1'b0;
         end
      join

      // arbitration: grant withheld 10 cycles
      bus_grant = 1'b0;
      base = bytes_seen;
      fork
         run_frame("arb", 16'h1234, FRAME_CYC + 10);
         begin
            tick();
            for (int i = 0; i < 10; i++) begin
               check("arb_bus_req", bus_req, 1);
               check("arb_oe", data_out_enable, 0);
               check("arb_wr_n", wr_n, 1);
               tick();
            end
            check("arb_no_write", bytes_seen, base);
            bus_grant = 1'b1;
         end
      join

      // request while busy is dropped
      base = done_cnt;
      fork
         run_frame("drop", 16'h8001, FRAME_CYC);
         begin
            repeat (15) tick();
            send_req = 1'b1;
            tick();
            send_req = 1'b0;
         end
      join
      repeat (5) tick();
      check("drop_one_done", done_cnt, base + 1);
      check("drop_not_queued", busy, 0);
      run_frame("after_drop", 16'h0F0F, FRAME_CYC);

      // reset during STROBE of byte 1
      base = bytes_seen;
      panel_switches = 16'hBEEF;
      push_frame(16'hBEEF);
      send_req = 1'b1;
      tick();
      send_req = 1'b0;
      k = 0;
      while (!(bytes_seen == base + 1 && state_out == 3'd4) && k < 200) begin
         @(negedge clk);
         #1;
         k++;
      end
      check("rst_mid_reach", state_out, 3'd4);
      reset_n = 1'b0;
      tick();
      check("rst_mid_wr_n", wr_n, 1);
      check("rst_mid_oe", data_out_enable, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_bus_req", bus_req, 0);
      check("rst_mid_state", state_out, 3'd0);
      tick();
      reset_n = 1'b1;
      exp_q.delete();
      exp_seq = 8'h00;
      repeat (2) tick();
      run_frame("post_rst", 16'hFDEC, FRAME_CYC);

      // sequence wrap: frames 2..257 after reset (frame 256 seq FF, 257 seq 00)
      for (int i = 2; i <= 257; i++) begin
         run_frame("wrap", 16'(i * 16'h0101) ^ 16'h5AC3, FRAME_CYC);
      end
      check("wrap_seq_model", exp_seq, 8'h01);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
